// File: rtl/serial_chunk_subtractor.sv
// Serial subtractor: diff = a - b - bin, CHUNK bits per clock (LSB chunk first), valid/ready both sides.
// Define SCS_SIGNED_OVF_EN to build the signed-overflow flag; otherwise ovf is tied low.
module serial_chunk_subtractor #(
  parameter int SIZE  = 16,
  parameter int CHUNK = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
  input  logic            bin,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [SIZE-1:0] diff,
  output logic            borrow_out,
  output logic            ovf
);

  localparam int NCH   = SIZE / CHUNK;
  localparam int CNT_W = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NCH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e           state_q;
  logic [SIZE-1:0]  a_q, b_q, diff_q;
  logic             borrow_q, borrow_out_q;
  logic             in_ready_q, out_valid_q;
  logic [CNT_W-1:0] cnt_q;

  logic [CHUNK-1:0] a_chunk, b_chunk, chunk_d;
  logic             bw_d;
  int               lo;

  // One CHUNK+1-bit subtract per cycle; the extra MSB is the chunk's borrow-out.
  always_comb begin
    lo      = int'(cnt_q) * CHUNK;
    a_chunk = a_q[lo +: CHUNK];
    b_chunk = b_q[lo +: CHUNK];
    {bw_d, chunk_d} = {1'b0, a_chunk} - {1'b0, b_chunk} - {{CHUNK{1'b0}}, borrow_q};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      diff_q       <= '0;
      borrow_q     <= 1'b0;
      borrow_out_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            a_q          <= a;
            b_q          <= b;
            borrow_q     <= bin;
            diff_q       <= '0;
            borrow_out_q <= 1'b0;
            cnt_q        <= '0;
            in_ready_q   <= 1'b0;
            state_q      <= S_RUN;
          end
        end
        S_RUN: begin
          diff_q[lo +: CHUNK] <= chunk_d;
          borrow_q            <= bw_d;
          cnt_q               <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            cnt_q        <= '0;
            borrow_out_q <= bw_d;
            out_valid_q  <= 1'b1;
            state_q      <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef SCS_SIGNED_OVF_EN
  logic ovf_q;

  // Top result bit is the MSB of the final chunk, still combinational at the last RUN edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (state_q == S_IDLE && in_valid) begin
      ovf_q <= 1'b0;
    end else if (state_q == S_RUN && cnt_q == LAST) begin
      ovf_q <= (a_q[SIZE-1] != b_q[SIZE-1]) && (chunk_d[CHUNK-1] != a_q[SIZE-1]);
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign diff       = diff_q;
  assign borrow_out = borrow_out_q;

endmodule

// File: tb/tb_serial_chunk_subtractor.sv
// Randomized self-checking bench for serial_chunk_subtractor (SIZE=16, CHUNK=4) against an arithmetic model.
module tb_serial_chunk_subtractor;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        bin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] diff;
  logic        borrow_out;
  logic        ovf;

  int checks;
  int failures;

  serial_chunk_subtractor #(.SIZE(16), .CHUNK(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .bin        (bin),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .diff       (diff),
    .borrow_out (borrow_out),
    .ovf        (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Returns {ovf, borrow, diff}
  function automatic logic [17:0] ref_sub(input logic [15:0] ra, input logic [15:0] rb, input logic rbin);
    logic [16:0] r;
    logic        o;
    r = {1'b0, ra} - {1'b0, rb} - {16'd0, rbin};
`ifdef SCS_SIGNED_OVF_EN
    o = (ra[15] != rb[15]) && (r[15] != ra[15]);
`else
    o = 1'b0;
`endif
    return {o, r[16], r[15:0]};
  endfunction

  task automatic run_op(input logic [15:0] oa, input logic [15:0] ob, input logic obin,
                        input int stall, input bit noise);
    logic [17:0] exp;
    int n;
    exp = ref_sub(oa, ob, obin);
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk("in_ready_wait", {31'd0, in_ready}, 32'd1);
    a = oa; b = ob; bin = obin; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 16'($urandom); b = 16'($urandom); bin = 1'($urandom);
    n = 0;
    while (!out_valid && n < 20) begin
      if (noise) begin
        in_valid  = 1'($urandom);
        out_ready = 1'($urandom);
        a = 16'($urandom); b = 16'($urandom); bin = 1'($urandom);
      end
      @(posedge clk); #1; n++;
    end
    chk("latency", n, 32'd4);
    out_ready = 1'b0;
    for (int i = 0; i < stall; i++) begin
      if (noise) begin
        in_valid = 1'($urandom);
        a = 16'($urandom); b = 16'($urandom);
      end
      @(posedge clk); #1;
      chk("hold_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_diff", {16'd0, diff}, {16'd0, exp[15:0]});
      chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
    end
    chk("diff", {16'd0, diff}, {16'd0, exp[15:0]});
    chk("borrow_out", {31'd0, borrow_out}, {31'd0, exp[16]});
    chk("ovf", {31'd0, ovf}, {31'd0, exp[17]});
    out_ready = 1'b1;
    if (noise) in_valid = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk("release_valid", {31'd0, out_valid}, 32'd0);
    chk("release_in_ready", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; bin = 1'b0;
    #3;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_diff", {16'd0, diff}, 32'd0);
    chk("rst_borrow", {31'd0, borrow_out}, 32'd0);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
    #14 rst = 1'b0;
    @(posedge clk); #1;

    run_op(16'h1234, 16'h0234, 1'b0, 0, 1'b0);
    run_op(16'h0000, 16'h0001, 1'b0, 0, 1'b0);
    run_op(16'h0005, 16'h0005, 1'b1, 0, 1'b0);
    run_op(16'h8000, 16'h0001, 1'b0, 0, 1'b0);
    run_op(16'h7FFF, 16'hFFFF, 1'b0, 1, 1'b0);
    run_op(16'hBEEF, 16'h1234, 1'b1, 10, 1'b1);

    // Abort mid-RUN after a few chunks have been computed
    a = 16'hFFFF; b = 16'h0001; bin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); @(posedge clk); @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
    chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_diff", {16'd0, diff}, 32'd0);
    chk("abort_borrow", {31'd0, borrow_out}, 32'd0);
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("abort_no_result", {31'd0, out_valid}, 32'd0);
    end
    run_op(16'h4321, 16'h1234, 1'b1, 0, 1'b0);

    for (int i = 0; i < 1000; i++) begin
      run_op(16'($urandom), 16'($urandom), 1'($urandom), $urandom_range(0, 3), 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
